player_motion: RTL and testbench
================================

Name: player_motion

Overview:
- Parametrised successor to the fixed-step player block: horizontal movement with a velocity ramp, exact edge clamping and a frame-synchronous double-buffered position.
- Sits between the debounced button inputs and the sprite renderer / collision logic.
- Internal position updates on move ticks. Published position changes only at the frame (blanking) pulse, so the renderer never sees a mid-frame change.

Parameters:
- COORD_W, 10, width of coordinate outputs and internal position.
- RES_H, 640, horizontal resolution in pixels.
- SPRITE_W, 32, scaled sprite width in pixels. XMAX = RES_H - SPRITE_W.
- START_X, 304, x position after reset, done or game restart.
- START_Y, 440, y position (constant during play).
- STEP_MIN, 1, pixels per move tick when motion starts.
- STEP_MAX, 4, pixels per move tick at full speed. Requires STEP_MIN <= STEP_MAX <= XMAX.
- RAMP_TICKS, 8, consecutive same-direction move ticks before step increases by 1. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_move  in  1  one-cycle move tick enable
- frame  in  1  one-cycle pulse at start of blanking
- left  in  1  debounced left button
- right  in  1  debounced right button
- done  in  1  game over / restart; treated as a synchronous reset of position and ramp
- player_x  out  COORD_W  published x, registered
- player_y  out  COORD_W  published y, registered
- moving  out  1  high while state != IDLE, registered
- at_edge  out  1  internal x == 0 or x == XMAX, registered

Behaviour:
- Clock and reset:
  - Single clock domain, clk. No asynchronous reset.
  - rst or done (sync, same cycle) forces: x_int = START_X, player_x = START_X, player_y = START_Y, step = STEP_MIN, ramp_cnt = 0, state = IDLE, moving = 0, at_edge = 0.
  - rst/done override frame and clk_move in the same cycle. Reset mid-ramp discards the ramp.
- Direction decode: dir = L if left & ~right; R if right & ~left; NONE otherwise (both or neither pressed).
- FSM states: IDLE, RAMP, CRUISE. Evaluated only on cycles with clk_move = 1; otherwise state is held.
  - dir = NONE -> IDLE; step = STEP_MIN; ramp_cnt = 0; no movement.
  - dir != last_dir, or state == IDLE -> RAMP (CRUISE if STEP_MIN == STEP_MAX).
    - Move by STEP_MIN; step = STEP_MIN; ramp_cnt = 1; last_dir = dir.
  - Same dir in RAMP:
    - If ramp_cnt == RAMP_TICKS: step += 1, ramp_cnt = 1, then move by the new step.
    - Otherwise: ramp_cnt += 1, move by step.
    - When step reaches STEP_MAX -> CRUISE.
  - Same dir in CRUISE: move by STEP_MAX.
  - A direction reversal restarts at STEP_MIN. There is no carry-over of speed.
- Arithmetic:
  - Compute in COORD_W+1 bits. No unsigned underflow is permitted.
  - Left: x_int = (x_int < step) ? 0 : x_int - step.
  - Right: x_int = (x_int + step > XMAX) ? XMAX : x_int + step.
  - Clamping lands exactly on the edge. The ramp keeps running while pinned.
- Publishing:
  - On frame = 1: player_x <= x_int (value before any same-cycle move update); player_y <= START_Y.
  - If frame and clk_move coincide, the move still applies to x_int. It is published at the next frame.
- Status outputs:
  - moving: registered from the next state.
  - at_edge: registered from the next x_int.
- Latency:
  - Move tick to x_int: 1 cycle.
  - x_int to player_x: at the next frame pulse.

Optional Feature:
- Macro: PLAYER_WRAP_EN.
- Defined: edges wrap instead of clamp.
  - Left with x_int < step -> x_int = x_int - step + XMAX + 1.
  - Right with x_int + step > XMAX -> x_int = x_int + step - XMAX - 1.
  - at_edge is tied to 0.
- Undefined: clamping as above.

Test Plan:
- Reset, no input: rst 1 cycle, then 3 frames -> player_x = 304, player_y = 440, moving = 0, at_edge = 0.
- Ramp, right held for 24 move ticks, then frame -> player_x = 352 (8x1 + 8x2 + 8x3 steps). Tick 25 uses step 4 and moving = 1 -> state CRUISE. player_x is unchanged between frames.
- Reversal: after reaching CRUISE moving right, switch to left -> next tick moves by 1, not 4. Both buttons held -> no movement, moving = 0.
- Left clamp: x_int = 2 in CRUISE, left tick -> x_int = 0, at_edge = 1. Further left ticks -> x stays 0.
- Right clamp: x_int = 606, right tick with step 4 -> x_int = 608, at_edge = 1.
- Wrap (PLAYER_WRAP_EN): x_int = 2, step 4, left tick -> 607. x_int = 607, step 4, right tick -> 2.
- Reset with overlapping events: done asserted on the same cycle as frame and clk_move mid-ramp -> player_x = 304 next cycle, step = 1, state = IDLE.

Source files
------------

// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
//
// Horizontal player movement with a step ramp, exact edge handling and a
// frame-synchronous published position. The internal position x_int moves on
// clk_move ticks; player_x/player_y change only on the frame pulse, so the
// renderer never sees a position change part-way through a frame.
//
// Configuration macro:
//   PLAYER_WRAP_EN  defined   -> edges wrap around, at_edge is tied to 0
//                   undefined -> position clamps exactly on 0 / XMAX
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clk_move  in   one-cycle move tick enable
//   frame     in   one-cycle pulse at start of blanking (publishes x_int)
//   left      in   debounced left button
//   right     in   debounced right button
//   done      in   game over / restart, acts as a synchronous reset
//   player_x  out  published x (registered)
//   player_y  out  published y (registered, constant START_Y)
//   moving    out  high while the FSM is not IDLE (registered)
//   at_edge   out  internal x is at 0 or XMAX (registered)
// -----------------------------------------------------------------------------
module player_motion #(
    parameter int COORD_W    = 10,
    parameter int RES_H      = 640,
    parameter int SPRITE_W   = 32,
    parameter int START_X    = 304,
    parameter int START_Y    = 440,
    parameter int STEP_MIN   = 1,
    parameter int STEP_MAX   = 4,
    parameter int RAMP_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_move,
    input  logic               frame,
    input  logic               left,
    input  logic               right,
    input  logic               done,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic               moving,
    output logic               at_edge
);

    localparam int XMAX  = RES_H - SPRITE_W;
    localparam int CNT_W = (RAMP_TICKS < 2) ? 1 : $clog2(RAMP_TICKS + 1);

    localparam logic [COORD_W-1:0] START_X_C    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C    = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] STEP_MIN_C   = COORD_W'(STEP_MIN);
    localparam logic [COORD_W-1:0] STEP_MAX_C   = COORD_W'(STEP_MAX);
    localparam logic [CNT_W-1:0]   RAMP_TICKS_C = CNT_W'(RAMP_TICKS);
    localparam logic [COORD_W:0]   XMAX_W       = (COORD_W + 1)'(XMAX);
`ifdef PLAYER_WRAP_EN
    localparam logic [COORD_W:0]   XMAX_P1      = (COORD_W + 1)'(XMAX + 1);
`else
    localparam logic [COORD_W-1:0] XMAX_C       = COORD_W'(XMAX);
`endif

    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} state_t;

    state_t             state, state_nxt;
    logic [COORD_W-1:0] x_int, x_nxt;
    logic [COORD_W-1:0] step, step_nxt;
    logic [COORD_W-1:0] mv_step;
    logic [CNT_W-1:0]   ramp_cnt, cnt_nxt;
    logic               last_dir, last_dir_nxt;   // 1 = right, 0 = left
    logic               go_l, go_r, dir_none;
    logic               edge_nxt;

    // Edge handling is done one bit wider than the coordinate so that neither
    // x - step can underflow nor x + step can overflow before the compare.
    function automatic logic [COORD_W-1:0] move_left(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] s);
        logic [COORD_W:0] xe, se, r;
        xe = {1'b0, x};
        se = {1'b0, s};
`ifdef PLAYER_WRAP_EN
        if (xe < se) r = xe + XMAX_P1 - se;
        else         r = xe - se;
`else
        if (xe < se) r = '0;
        else         r = xe - se;
`endif
        return COORD_W'(r);
    endfunction

    function automatic logic [COORD_W-1:0] move_right(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] s);
        logic [COORD_W:0] sum, r;
        sum = {1'b0, x} + {1'b0, s};
`ifdef PLAYER_WRAP_EN
        if (sum > XMAX_W) r = sum - XMAX_P1;
        else              r = sum;
`else
        if (sum > XMAX_W) r = {1'b0, XMAX_C};
        else              r = sum;
`endif
        return COORD_W'(r);
    endfunction

    assign go_l     = left & ~right;
    assign go_r     = right & ~left;
    assign dir_none = ~(go_l | go_r);

    // Next-state, ramp and position update; nothing changes off move ticks.
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        cnt_nxt      = ramp_cnt;
        last_dir_nxt = last_dir;
        x_nxt        = x_int;
        mv_step      = STEP_MIN_C;
        if (clk_move) begin
            if (dir_none) begin
                state_nxt = IDLE;
                step_nxt  = STEP_MIN_C;
                cnt_nxt   = '0;
            end else if (state == IDLE || go_r != last_dir) begin
                // Fresh start or reversal: speed never carries over.
                state_nxt    = (STEP_MIN == STEP_MAX) ? CRUISE : RAMP;
                step_nxt     = STEP_MIN_C;
                cnt_nxt      = CNT_W'(1);
                last_dir_nxt = go_r;
                mv_step      = STEP_MIN_C;
            end else if (state == RAMP) begin
                if (ramp_cnt == RAMP_TICKS_C) begin
                    step_nxt = step + 1'b1;
                    cnt_nxt  = CNT_W'(1);
                end else begin
                    cnt_nxt  = ramp_cnt + 1'b1;
                end
                // The tick that raises the step already moves by the new step.
                mv_step = step_nxt;
                if (step_nxt == STEP_MAX_C) state_nxt = CRUISE;
            end else begin
                mv_step = STEP_MAX_C;
            end
            if (!dir_none) x_nxt = go_r ? move_right(x_int, mv_step)
                                        : move_left(x_int, mv_step);
        end
    end

`ifdef PLAYER_WRAP_EN
    assign edge_nxt = 1'b0;
`else
    assign edge_nxt = (x_nxt == '0) || (x_nxt == XMAX_C);
`endif

    always_ff @(posedge clk) begin
        if (rst || done) state <= IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            step     <= STEP_MIN_C;
            ramp_cnt <= '0;
            last_dir <= 1'b0;
            x_int    <= START_X_C;
            player_x <= START_X_C;
            player_y <= START_Y_C;
            moving   <= 1'b0;
            at_edge  <= 1'b0;
        end else begin
            step     <= step_nxt;
            ramp_cnt <= cnt_nxt;
            last_dir <= last_dir_nxt;
            x_int    <= x_nxt;
            moving   <= (state_nxt != IDLE);
            at_edge  <= edge_nxt;
            // Publish the pre-update position; a coinciding move shows next frame.
            if (frame) begin
                player_x <= x_int;
                player_y <= START_Y_C;
            end
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// -----------------------------------------------------------------------------
// tb_player_motion
//
// Scoreboard bench for player_motion (default clamping build). Stimulus pushes
// the hand-computed published state into a queue before every frame / reset /
// done event; an independent monitor pops and compares whenever the DUT
// republishes, and on all other cycles checks that player_x holds still.
// -----------------------------------------------------------------------------
module tb_player_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_move = 1'b0;
    logic       frame = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       done = 1'b0;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       moving;
    logic       at_edge;

    always #5 clk = ~clk;

    player_motion dut (
        .clk      (clk),
        .rst      (rst),
        .clk_move (clk_move),
        .frame    (frame),
        .left     (left),
        .right    (right),
        .done     (done),
        .player_x (player_x),
        .player_y (player_y),
        .moving   (moving),
        .at_edge  (at_edge)
    );

    typedef struct {
        string name;
        int    x;
        int    y;
        bit    mv;
        bit    ae;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pub_seen = 1'b0;

    // A publish happens on any cycle that had frame, rst or done asserted.
    always @(posedge clk) pub_seen <= frame | rst | done;

    // Monitor
    initial begin
        bit         armed;
        logic [9:0] last_x;
        armed  = 0;
        last_x = '0;
        forever begin
            @(negedge clk);
            if (pub_seen) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_publish: got player_x=%0d with nothing queued", player_x);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (player_x !== 10'(e.x) || player_y !== 10'(e.y) ||
                        moving !== e.mv || at_edge !== e.ae) begin
                        n_bad++;
                        $display("FAIL %s: got x=%0d y=%0d moving=%0b at_edge=%0b, want x=%0d y=%0d moving=%0b at_edge=%0b",
                                 e.name, player_x, player_y, moving, at_edge, e.x, e.y, e.mv, e.ae);
                    end
                end
                armed = 1;
            end else if (armed) begin
                n_cmp++;
                if (player_x !== last_x) begin
                    n_bad++;
                    $display("FAIL hold_between_frames: got player_x=%0d, want %0d", player_x, last_x);
                end
            end
            last_x = player_x;
        end
    end

    task automatic cyc(input bit mv, input bit fr, input bit dn, input bit rs);
        clk_move = mv;
        frame    = fr;
        done     = dn;
        rst      = rs;
        @(posedge clk);
        #1;
        clk_move = 1'b0;
        frame    = 1'b0;
        done     = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic expect_pub(input string nm, input int x, input bit mv, input bit ae);
        exp_t e;
        e.name = nm;
        e.x    = x;
        e.y    = 440;
        e.mv   = mv;
        e.ae   = ae;
        sb.push_back(e);
    endtask

    task automatic publish(input string nm, input int x, input bit mv, input bit ae);
        expect_pub(nm, x, mv, ae);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n, input bit l, input bit r);
        left  = l;
        right = r;
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Stimulus
    initial begin
        // Reset and idle frames
        expect_pub("reset", 304, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        publish("idle_frame1", 304, 0, 0);
        publish("idle_frame2", 304, 0, 0);
        publish("idle_frame3", 304, 0, 0);

        // Ramp right: 8x1 + 8x2 + 8x3, then step 4 in CRUISE
        ticks(24, 0, 1);
        publish("ramp24", 352, 1, 0);
        ticks(1, 0, 1);
        publish("tick25_step4", 356, 1, 0);
        ticks(1, 0, 1);
        publish("cruise_step4", 360, 1, 0);

        // Reversal restarts at step 1; both buttons stop motion
        ticks(1, 1, 0);
        publish("reverse_step1", 359, 1, 0);
        ticks(1, 1, 1);
        publish("both_held", 359, 0, 0);

        // Restart, then walk left to x=2 in CRUISE
        expect_pub("done_restart", 304, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2, 0, 1);                 // 306
        ticks(1, 0, 0);                 // back to IDLE
        ticks(24, 1, 0);                // 258
        ticks(64, 1, 0);                // 2
        publish("cruise_x2", 2, 1, 0);
        ticks(1, 1, 0);
        publish("left_clamp", 0, 1, 1);
        ticks(2, 1, 0);
        publish("left_pinned", 0, 1, 1);

        // Walk right to x=606 in CRUISE, then clamp on XMAX
        ticks(2, 0, 1);                 // 2
        ticks(1, 0, 0);                 // IDLE
        ticks(24, 0, 1);                // 50
        ticks(139, 0, 1);               // 606
        publish("cruise_x606", 606, 1, 0);
        ticks(1, 0, 1);
        publish("right_clamp", 608, 1, 1);
        ticks(1, 0, 1);
        publish("right_pinned", 608, 1, 1);

        // Mid-ramp, then done colliding with frame and a move tick
        ticks(3, 1, 0);
        publish("mid_ramp", 605, 1, 0);
        expect_pub("done_overlap", 304, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        expect_pub("frame_with_tick", 304, 1, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        publish("after_restart_step1", 303, 1, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
